// File: rtl/fc_pkg.sv
// Shared types and constants for the fully-connected bias/activation stage.
package fc_pkg;

    localparam int FC_DATA_WIDTH = 16;
    localparam int FC_ACC_WIDTH  = 40;
    localparam int FC_FRAC_BITS  = 8;
    localparam int FC_BATCH_SIZE = 16;
    localparam int FC_DEPTH      = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } fc_state_e;

    function automatic longint sat_max(input int dw);
        return (longint'(1) <<< (dw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction

endpackage

// File: rtl/fc_sat_lane.sv
// One lane: rescale accumulator, add bias, saturate to DATA_WIDTH.
// Optional ReLU when FC_RELU_EN is defined.
module fc_sat_lane
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = FC_DATA_WIDTH,
    parameter int ACC_WIDTH  = FC_ACC_WIDTH,
    parameter int FRAC_BITS  = FC_FRAC_BITS
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    input  logic [DATA_WIDTH-1:0] bias,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int SW = ACC_WIDTH + 1;
    localparam logic signed [SW-1:0] MAX_S = SW'(sat_max(DATA_WIDTH));
    localparam logic signed [SW-1:0] MIN_S = SW'(sat_min(DATA_WIDTH));

    logic signed [ACC_WIDTH-1:0]  acc_sh;
    logic signed [SW-1:0]         sum;
    logic        [DATA_WIDTH-1:0] sat;

    always_comb begin
        acc_sh = $signed(acc) >>> FRAC_BITS;
        // One extra bit so the add itself cannot overflow before clamping
        sum    = {acc_sh[ACC_WIDTH-1], acc_sh}
               + {{(SW - DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
        if (sum > MAX_S) begin
            sat = MAX_S[DATA_WIDTH-1:0];
        end else if (sum < MIN_S) begin
            sat = MIN_S[DATA_WIDTH-1:0];
        end else begin
            sat = sum[DATA_WIDTH-1:0];
        end
`ifdef FC_RELU_EN
        result = sat[DATA_WIDTH-1] ? '0 : sat;
`else
        result = sat;
`endif
    end

endmodule

// File: rtl/fc_bias_act.sv
// Bias-add / saturate / activation stage between MAC array and output writer.
// Define FC_RELU_EN to clamp negative results to zero.
module fc_bias_act
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = FC_DATA_WIDTH,
    parameter int ACC_WIDTH  = FC_ACC_WIDTH,
    parameter int FRAC_BITS  = FC_FRAC_BITS,
    parameter int BATCH_SIZE = FC_BATCH_SIZE,
    parameter int DEPTH      = FC_DEPTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [BATCH_SIZE*ACC_WIDTH-1:0]  acc_in,
    input  logic                             acc_valid,
    output logic                             acc_ready,
    input  logic                             bias_valid,
    output logic                             bias_rd_en,
    input  logic [BATCH_SIZE*DATA_WIDTH-1:0] bias_in,
    output logic [BATCH_SIZE*DATA_WIDTH-1:0] out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic [((DEPTH/BATCH_SIZE > 1) ? $clog2(DEPTH/BATCH_SIZE) : 1)-1:0] batch_idx
);

    localparam int NUM_BATCHES = DEPTH / BATCH_SIZE;
    localparam int IDX_W = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BATCHES - 1);

    fc_state_e                        state_q, state_d;
    logic [BATCH_SIZE*ACC_WIDTH-1:0]  acc_q;
    logic [BATCH_SIZE*DATA_WIDTH-1:0] lane_res;
    logic [BATCH_SIZE*DATA_WIDTH-1:0] out_data_q;
    logic [IDX_W-1:0]                 idx_q;
    logic                             acc_fire;
    logic                             out_fire;

    for (genvar i = 0; i < BATCH_SIZE; i++) begin : g_lane
        fc_sat_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .FRAC_BITS  (FRAC_BITS)
        ) u_lane (
            .acc    (acc_q[i*ACC_WIDTH +: ACC_WIDTH]),
            .bias   (bias_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .result (lane_res[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Held low while reset is asserted even though the state already reads IDLE
    assign acc_ready  = (state_q == IDLE) && !reset;
    assign acc_fire   = acc_valid && acc_ready;
    assign bias_rd_en = (state_q == REQ) && bias_valid;
    assign out_valid  = (state_q == OUT);
    assign out_fire   = out_valid && out_ready;
    assign out_last   = out_valid && (idx_q == LAST_IDX);
    assign out_data   = out_data_q;
    assign batch_idx  = idx_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (acc_fire)   state_d = REQ;
            REQ:  if (bias_valid) state_d = WAIT;
            WAIT:                 state_d = OUT;
            OUT:  if (out_ready)  state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            out_data_q <= '0;
            idx_q      <= '0;
        end else begin
            state_q <= state_d;
            if (acc_fire) begin
                acc_q <= acc_in;
            end
            // bias_in is valid in WAIT, one cycle after the read request
            if (state_q == WAIT) begin
                out_data_q <= lane_res;
            end
            if (out_fire) begin
                idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fc_bias_act.sv
// Scoreboard bench for fc_bias_act with directed, hand-computed vectors.
module tb_fc_bias_act;

    localparam int DW = 16;
    localparam int AW = 40;
    localparam int BS = 16;
    localparam int DP = 64;
    localparam int IW = 2;

    typedef struct {
        logic [BS*DW-1:0] data;
        logic             last;
        logic [IW-1:0]    idx;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [BS*AW-1:0] acc_in = '0;
    logic             acc_valid = 1'b0;
    logic             acc_ready;
    logic             bias_valid = 1'b1;
    logic             bias_rd_en;
    logic [BS*DW-1:0] bias_in = '0;
    logic [BS*DW-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_last;
    logic [IW-1:0]    batch_idx;

    int   checks = 0;
    int   errors = 0;
    int   rd_cnt = 0;
    int   model_idx = 0;
    exp_t exp_q[$];

    logic [AW-1:0] a_l [BS];
    logic [DW-1:0] b_l [BS];
    logic [DW-1:0] e_l [BS];

    fc_bias_act #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .FRAC_BITS  (8),
        .BATCH_SIZE (BS),
        .DEPTH      (DP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .acc_in     (acc_in),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .bias_valid (bias_valid),
        .bias_rd_en (bias_rd_en),
        .bias_in    (bias_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .batch_idx  (batch_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && bias_rd_en) rd_cnt <= rd_cnt + 1;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per output handshake
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 256'd1, 256'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_last", out_last, e.last);
                check("batch_idx", batch_idx, e.idx);
            end
        end
    end

    task automatic clear_lanes();
        for (int i = 0; i < BS; i++) begin
            a_l[i] = '0;
            b_l[i] = '0;
            e_l[i] = '0;
        end
    endtask

    task automatic send(input bit push);
        exp_t e;
        int t;
        for (int i = 0; i < BS; i++) begin
            acc_in[i*AW +: AW]  = a_l[i];
            bias_in[i*DW +: DW] = b_l[i];
            e.data[i*DW +: DW]  = e_l[i];
        end
        t = 0;
        while (!acc_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc_ready) begin
            check("acc_ready_timeout", 256'd0, 256'd1);
            return;
        end
        acc_valid = 1'b1;
        if (push) begin
            e.idx  = model_idx[IW-1:0];
            e.last = (model_idx == DP / BS - 1);
            exp_q.push_back(e);
            model_idx = (model_idx + 1) % (DP / BS);
        end
        @(posedge clk);
        #1;
        acc_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int rd0;
        logic [BS*DW-1:0] snap_data;
        logic snap_last;
        int t;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_acc_ready", acc_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_bias_rd_en", bias_rd_en, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_batch_idx", batch_idx, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_acc_ready", acc_ready, 1);

        // Batch 0: arithmetic corners plus minimum latency
        clear_lanes();
        a_l[0] = 40'h00_0003_0000; b_l[0] = 16'h0100; e_l[0] = 16'h0400;
        a_l[1] = 40'h00_0000_0300; b_l[1] = 16'h0100; e_l[1] = 16'h0103;
        a_l[2] = 40'h00_7FFF_0000; b_l[2] = 16'h7FFF; e_l[2] = 16'h7FFF;
        a_l[6] = 40'h00_0000_00FF; b_l[6] = 16'h0005; e_l[6] = 16'h0005;
        a_l[3] = 40'hFF_8000_0000; b_l[3] = 16'h8000;
        a_l[4] = 40'hFF_FFFE_8000; b_l[4] = 16'h0080;
        a_l[5] = 40'hFF_FFFF_FFFF; b_l[5] = 16'h0000;
`ifdef FC_RELU_EN
        e_l[3] = 16'h0000; e_l[4] = 16'h0000; e_l[5] = 16'h0000;
`else
        e_l[3] = 16'h8000; e_l[4] = 16'hFF00; e_l[5] = 16'hFFFF;
`endif
        send(1'b1);
        @(negedge clk);
        check("lat_req_rd_en", bias_rd_en, 1);
        check("lat_req_acc_ready", acc_ready, 0);
        check("lat_req_out_valid", out_valid, 0);
        @(negedge clk);
        check("lat_wait_rd_en", bias_rd_en, 0);
        check("lat_wait_out_valid", out_valid, 0);
        @(negedge clk);
        check("lat_out_valid", out_valid, 1);
        @(negedge clk);
        check("lat_back_idle", acc_ready, 1);
        drain();

        // Batch 1: bias RAM empty for 10 cycles
        clear_lanes();
        a_l[0] = 40'h00_0001_0000; b_l[0] = 16'h0002; e_l[0] = 16'h0102;
        bias_valid = 1'b0;
        rd0 = rd_cnt;
        send(1'b1);
        repeat (10) begin
            @(negedge clk);
            check("stall_rd_en", bias_rd_en, 0);
            check("stall_out_valid", out_valid, 0);
        end
        check("stall_rd_cnt", rd_cnt - rd0, 0);
        bias_valid = 1'b1;
        #1;
        check("unstall_rd_en", bias_rd_en, 1);
        @(negedge clk);
        check("unstall_wait_valid", out_valid, 0);
        @(negedge clk);
        check("unstall_out_valid", out_valid, 1);
        drain();
        check("unstall_one_pulse", rd_cnt - rd0, 1);

        // Batch 2: consumer back-pressure
        clear_lanes();
        a_l[15] = 40'hFF_FFFF_0000; b_l[15] = 16'h0300; e_l[15] = 16'h0200;
        out_ready = 1'b0;
        rd0 = rd_cnt;
        send(1'b1);
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("bp_out_valid", out_valid, 1);
        snap_data = out_data;
        snap_last = out_last;
        repeat (5) begin
            @(negedge clk);
            check("bp_data_stable", out_data, snap_data);
            check("bp_last_stable", out_last, snap_last);
            check("bp_acc_ready", acc_ready, 0);
        end
        check("bp_rd_cnt", rd_cnt - rd0, 1);
        out_ready = 1'b1;
        drain();

        // Batch 3 is last of the layer; batch 4 wraps to index 0
        clear_lanes();
        a_l[8] = 40'h00_0000_1234; b_l[8] = 16'hFFF0; e_l[8] = 16'h0002;
        send(1'b1);
        drain();
        clear_lanes();
        a_l[1] = 40'h7F_FFFF_FFFF; b_l[1] = 16'h0000; e_l[1] = 16'h7FFF;
        send(1'b1);
        drain();

        // Reset while in WAIT discards the pending batch
        clear_lanes();
        a_l[0] = 40'h00_0009_0000;
        send(1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rstw_out_valid", out_valid, 0);
        check("rstw_rd_en", bias_rd_en, 0);
        check("rstw_batch_idx", batch_idx, 0);
        check("rstw_acc_ready", acc_ready, 0);
        @(negedge clk);
        check("rstw_hold_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_idx = 0;
        @(negedge clk);
        check("rstw_idle", acc_ready, 1);
        check("rstw_out_last", out_last, 0);

        clear_lanes();
        a_l[0] = 40'h00_0002_0000; b_l[0] = 16'h0000; e_l[0] = 16'h0200;
        send(1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
